// File: rtl/shuffle_sequencer.sv
// Scramble sequencer for the puzzle board.
// A rising edge on the scramble button starts a shuffle of NUM_MOVES moves.
// Each move code is drawn from a free-running 8-bit LFSR. Code 7 is skipped,
// and so is an immediate repeat of the previous move. Every accepted move is
// offered to the board logic over a valid/ready handshake.
module shuffle_sequencer #(
  parameter int         NUM_MOVES = 16,
  parameter logic [7:0] SEED      = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scramble_btn,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [2:0] move_code,
  output logic       shuffling,
  output logic       done,
  output logic [7:0] moves_issued,
  output logic [7:0] rand_state
);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 01.
  localparam logic [7:0] SeedInit  = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0] LastCount = NUM_MOVES[7:0];

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HANDSHAKE,
    DONE
  } stateT;

  stateT      state;
  logic [7:0] lfsr;
  logic       feedback;
  logic       btnQ;
  logic       startQ;
  logic [2:0] cand;
  logic [2:0] lastCode;
  logic       haveLast;
  logic       candReject;
  logic       lastXfer;

  assign feedback   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign cand       = lfsr[7:5];
  assign candReject = (cand == 3'b111) || (haveLast && (cand == lastCode));
  assign lastXfer   = (moves_issued + 8'd1) == LastCount;
  assign rand_state = lfsr;

  // Free-running LFSR; it keeps stepping in every state, so the moment of the
  // button press decides which part of the sequence a shuffle uses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= SeedInit;
    end else begin
      // NOTE: non-blocking assignment, so every flop sees pre-edge values and
      // block evaluation order cannot change the result.
      lfsr <= {lfsr[6:0], feedback};
    end
  end

  // Rising-edge detect on the button. The start pulse is registered, and it
  // only fires while idle. btnQ always tracks the input, so a long press yields
  // exactly one start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btnQ   <= 1'b0;
      startQ <= 1'b0;
    end else begin
      btnQ   <= scramble_btn;
      startQ <= scramble_btn & ~btnQ & (state == IDLE);
    end
  end

  // Shuffle control FSM. All handshake and status outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      move_valid   <= 1'b0;
      move_code    <= 3'd0;
      shuffling    <= 1'b0;
      done         <= 1'b0;
      moves_issued <= 8'd0;
      lastCode     <= 3'd0;
      haveLast     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (startQ) begin
            moves_issued <= 8'd0;
            haveLast     <= 1'b0;
            shuffling    <= 1'b1;
            state        <= ISSUE;
          end
        end

        ISSUE: begin
          // A rejected candidate costs one cycle while the LFSR steps on.
          if (!candReject) begin
            move_code  <= cand;
            lastCode   <= cand;
            move_valid <= 1'b1;
            state      <= HANDSHAKE;
          end
        end

        HANDSHAKE: begin
          // move_valid is high throughout this state, so ready alone marks a
          // transfer.
          if (move_ready) begin
            moves_issued <= moves_issued + 8'd1;
            haveLast     <= 1'b1;
            move_valid   <= 1'b0;
            if (lastXfer) begin
              shuffling <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              state <= ISSUE;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shuffle_sequencer.sv
// Directed bench for shuffle_sequencer (NUM_MOVES=4), plus a second instance
// with SEED=0 that checks the seed substitution.
module tb_shuffle_sequencer;

  localparam int NumMoves = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scrambleBtn = 1'b0;
  logic       moveReady = 1'b0;
  logic       moveValid;
  logic [2:0] moveCode;
  logic       shuffling;
  logic       done;
  logic [7:0] movesIssued;
  logic [7:0] randState;

  logic       zValid;
  logic [2:0] zCode;
  logic       zShuffling;
  logic       zDone;
  logic [7:0] zIssued;
  logic [7:0] zState;

  shuffle_sequencer #(.NUM_MOVES(NumMoves), .SEED(8'h01)) dut (
    .clk          (clk),
    .rst          (rst),
    .scramble_btn (scrambleBtn),
    .move_ready   (moveReady),
    .move_valid   (moveValid),
    .move_code    (moveCode),
    .shuffling    (shuffling),
    .done         (done),
    .moves_issued (movesIssued),
    .rand_state   (randState)
  );

  shuffle_sequencer #(.NUM_MOVES(NumMoves), .SEED(8'h00)) dutZero (
    .clk          (clk),
    .rst          (rst),
    .scramble_btn (1'b0),
    .move_ready   (1'b0),
    .move_valid   (zValid),
    .move_code    (zCode),
    .shuffling    (zShuffling),
    .done         (zDone),
    .moves_issued (zIssued),
    .rand_state   (zState)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lfsrStep(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Reference LFSR and cycle counter.
  logic [7:0] modelLfsr;
  int         cycle = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) modelLfsr <= 8'h01;
    else     modelLfsr <= lfsrStep(modelLfsr);
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Transfer monitor; it samples on the falling edge.
  int         totalXfers = 0;
  int         totalDones = 0;
  int         lastXferCycle = 0;
  int         lastDoneCycle = 0;
  int         badCodes = 0;
  int         repeats = 0;
  int         holdViolations = 0;
  logic       prevValid = 1'b0;
  logic       prevReady = 1'b0;
  logic [2:0] prevCodeHeld = 3'd0;
  logic [2:0] lastIssued = 3'd0;
  logic       havePrev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prevValid = 1'b0;
      havePrev  = 1'b0;
    end else begin
      if (prevValid && !prevReady && (!moveValid || moveCode != prevCodeHeld))
        holdViolations++;
      if (moveValid && moveCode > 3'd6) badCodes++;
      if (done) begin
        totalDones++;
        lastDoneCycle = cycle;
      end
      if (!shuffling) havePrev = 1'b0;
      if (moveValid && moveReady) begin
        totalXfers++;
        lastXferCycle = cycle;
        if (havePrev && moveCode == lastIssued) repeats++;
        lastIssued = moveCode;
        havePrev   = 1'b1;
      end
      prevValid    = moveValid;
      prevReady    = moveReady;
      prevCodeHeld = moveCode;
    end
  end

  // Move to the stimulus point, just after the next rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pressButton();
    scrambleBtn = 1'b1;
    tick(1);
    scrambleBtn = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int d0 = totalDones;
    int k = 0;
    while (totalDones == d0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check({tag, "_done_seen"}, 32'(totalDones != d0), 32'd1);
    tick(1);
  endtask

  task automatic waitValid(input string tag, input int budget);
    int k = 0;
    @(negedge clk);
    while (!moveValid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(moveValid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq [5];
    logic [7:0] ahead;
    logic [2:0] heldCode;
    bit         expValid;
    bit         found;
    int         x0;
    int         d0;

    seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};

    // Reset state.
    tick(2);
    check("rst_valid", 32'(moveValid), 32'd0);
    check("rst_code", 32'(moveCode), 32'd0);
    check("rst_shuffling", 32'(shuffling), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_issued", 32'(movesIssued), 32'd0);
    check("rst_lfsr", 32'(randState), 32'h01);
    rst = 1'b0;

    // LFSR sequence after reset release, and the zero-seed substitution.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("lfsr_seq%0d", i), 32'(randState), 32'(seq[i]));
      if (i < 2) check($sformatf("lfsr_zero_seed%0d", i), 32'(zState), 32'(seq[i]));
    end
    tick(1);

    // Basic shuffle with ready held high.
    moveReady = 1'b1;
    ahead     = lfsrStep(lfsrStep(modelLfsr));
    expValid  = (ahead[7:5] != 3'b111);
    x0 = totalXfers;
    d0 = totalDones;
    pressButton();
    @(negedge clk);
    check("lat_idle_after_N", 32'(shuffling), 32'd0);
    @(negedge clk);
    check("lat_shuffling_N1", 32'(shuffling), 32'd1);
    check("lat_novalid_N1", 32'(moveValid), 32'd0);
    @(negedge clk);
    check("lat_valid_N2", 32'(moveValid), 32'(expValid));
    if (expValid) check("lat_code_N2", 32'(moveCode), 32'(ahead[7:5]));
    waitDone("basic", 200);
    check("basic_xfers", 32'(totalXfers - x0), 32'(NumMoves));
    check("basic_dones", 32'(totalDones - d0), 32'd1);
    check("basic_done_after_last", 32'(lastDoneCycle), 32'(lastXferCycle + 1));
    check("basic_issued", 32'(movesIssued), 32'(NumMoves));
    tick(5);
    check("basic_issued_hold", 32'(movesIssued), 32'(NumMoves));
    check("basic_idle", 32'(shuffling), 32'd0);

    // Second press while a shuffle is running is ignored.
    x0 = totalXfers;
    d0 = totalDones;
    pressButton();
    tick(4);
    check("repress_busy", 32'(shuffling), 32'd1);
    pressButton();
    waitDone("repress", 200);
    tick(10);
    check("repress_xfers", 32'(totalXfers - x0), 32'(NumMoves));
    check("repress_dones", 32'(totalDones - d0), 32'd1);

    // Button held for 100 cycles gives exactly one shuffle.
    x0 = totalXfers;
    d0 = totalDones;
    scrambleBtn = 1'b1;
    tick(100);
    scrambleBtn = 1'b0;
    tick(10);
    check("held_xfers", 32'(totalXfers - x0), 32'(NumMoves));
    check("held_dones", 32'(totalDones - d0), 32'd1);
    check("held_idle", 32'(shuffling), 32'd0);

    // Backpressure: valid and code hold while ready is low.
    moveReady = 1'b0;
    x0 = totalXfers;
    pressButton();
    waitValid("bp_valid_seen", 50);
    heldCode = moveCode;
    check("bp_issued0", 32'(movesIssued), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_valid_hold%0d", i), 32'(moveValid), 32'd1);
      check($sformatf("bp_code_hold%0d", i), 32'(moveCode), 32'(heldCode));
    end
    @(posedge clk);
    #1;
    moveReady = 1'b1;
    @(negedge clk);
    check("bp_valid_before_xfer", 32'(moveValid), 32'd1);
    @(negedge clk);
    check("bp_issued1", 32'(movesIssued), 32'd1);
    check("bp_valid_dropped", 32'(moveValid), 32'd0);
    waitDone("bp", 200);
    check("bp_xfers", 32'(totalXfers - x0), 32'(NumMoves));

    // Reset in HANDSHAKE after two transfers.
    moveReady = 1'b0;
    pressButton();
    for (int i = 0; i < 2; i++) begin
      waitValid($sformatf("mid_valid%0d", i), 50);
      @(posedge clk);
      #1;
      moveReady = 1'b1;
      @(posedge clk);
      #1;
      moveReady = 1'b0;
    end
    waitValid("mid_valid2", 50);
    check("mid_issued2", 32'(movesIssued), 32'd2);
    d0 = totalDones;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(moveValid), 32'd0);
    check("mid_rst_shuffling", 32'(shuffling), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_issued", 32'(movesIssued), 32'd0);
    check("mid_rst_lfsr", 32'(randState), 32'h01);
    tick(2);
    rst = 1'b0;
    tick(20);
    check("mid_no_done", 32'(totalDones - d0), 32'd0);
    check("mid_idle", 32'(shuffling), 32'd0);
    moveReady = 1'b1;
    x0 = totalXfers;
    pressButton();
    waitDone("post_rst", 200);
    check("post_rst_xfers", 32'(totalXfers - x0), 32'(NumMoves));
    check("post_rst_issued", 32'(movesIssued), 32'(NumMoves));

    // Rejection: the first candidate is time-aligned to code 7.
    tick(3);
    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      ahead = lfsrStep(lfsrStep(modelLfsr));
      if (ahead[7:5] == 3'b111) found = 1'b1;
      else tick(1);
    end
    check("rej_target_found", 32'(found), 32'd1);
    x0 = totalXfers;
    pressButton();
    @(negedge clk);
    @(negedge clk);
    check("rej_in_issue", 32'(shuffling), 32'd1);
    @(negedge clk);
    check("rej_extra_issue_cycle", 32'(moveValid), 32'd0);
    check("rej_lfsr_track", 32'(randState), 32'(modelLfsr));
    waitDone("rej", 200);
    check("rej_xfers", 32'(totalXfers - x0), 32'(NumMoves));

    // Properties accumulated over the whole run.
    check("no_code7", 32'(badCodes), 32'd0);
    check("no_repeats", 32'(repeats), 32'd0);
    check("valid_stable", 32'(holdViolations), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
